// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-memory line-port arbiter.
// FSM states, requester identities and a small state helper.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

    function automatic arb_state_t serve_state(input arb_src_t src);
        return (src == SRC_D) ? SERVE_D : SERVE_I;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-requester round-robin picker.
// On contention the requester that did not win last time is chosen.
module arb_rr_pick
    import arbiter_types::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  arb_src_t last_grant,
    output logic     grant_valid,
    output arb_src_t grant_src
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_src   = SRC_I;
        if (i_req && d_req) begin
            grant_src = (last_grant == SRC_I) ? SRC_D : SRC_I;
        end else if (d_req) begin
            grant_src = SRC_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory line port between the I-cache and D-cache miss paths.
// One transaction in flight; memory side is driven only from captured state.
module cache_mem_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t            state_q;
    arb_state_t            state_d;
    arb_src_t              last_grant;
    logic                  grant_valid;
    arb_src_t              grant_src;
    logic                  load;
    logic                  d_req;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [LINE_WIDTH-1:0] cap_wdata;
    logic                  cap_write;

    assign d_req = dcache_read | dcache_write;

    arb_rr_pick u_pick (
        .i_req       (icache_read),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    state_d = serve_state(grant_src);
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A simultaneous read+write from the D-cache is served as a writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= SRC_I;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_write  <= 1'b0;
        end else if (load) begin
            last_grant <= grant_src;
            if (grant_src == SRC_D) begin
                cap_addr  <= dcache_address;
                cap_wdata <= dcache_wdata;
                cap_write <= dcache_write;
            end else begin
                cap_addr  <= icache_address;
                cap_wdata <= '0;
                cap_write <= 1'b0;
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign mem_read     = busy & ~cap_write;
    assign mem_write    = busy & cap_write;
    assign mem_address  = cap_addr;
    assign mem_wdata    = cap_wdata;
    assign icache_resp  = (state_q == SERVE_I) & mem_resp;
    assign dcache_resp  = (state_q == SERVE_D) & mem_resp;
    assign icache_rdata = mem_rdata;
    assign dcache_rdata = mem_rdata;

    a_no_rw_both: assert property (
        @(posedge clk) disable iff (!reset) !(dcache_read && dcache_write)
    );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         icache_read = 1'b0;
    logic [15:0]  icache_address = '0;
    logic [127:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read = 1'b0;
    logic         dcache_write = 1'b0;
    logic [15:0]  dcache_address = '0;
    logic [127:0] dcache_wdata = '0;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the transaction currently owning the memory port.
    bit          t_open = 1'b0;
    bit          t_is_d = 1'b0;
    bit          t_wr = 1'b0;
    logic [15:0] t_addr = '0;
    logic [127:0] t_data = '0;
    bit          prev_winner_d = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_open        <= 1'b0;
            prev_winner_d <= 1'b0;
        end else if (!t_open) begin
            if (icache_read || dcache_read || dcache_write) begin
                bit want_d;
                if (icache_read && (dcache_read || dcache_write))
                    want_d = !prev_winner_d;
                else
                    want_d = !icache_read;
                t_open        <= 1'b1;
                t_is_d        <= want_d;
                prev_winner_d <= want_d;
                t_wr          <= want_d && dcache_write;
                t_addr        <= want_d ? dcache_address : icache_address;
                t_data        <= want_d ? dcache_wdata : '0;
            end
        end else if (mem_resp) begin
            t_open <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("cmp_mem_read", 128'(mem_read), 128'(t_open && !t_wr));
            check("cmp_mem_write", 128'(mem_write), 128'(t_open && t_wr));
            check("cmp_iresp", 128'(icache_resp),
                  128'(t_open && !t_is_d && mem_resp));
            check("cmp_dresp", 128'(dcache_resp),
                  128'(t_open && t_is_d && mem_resp));
            if (t_open) begin
                check("cmp_mem_address", 128'(mem_address), 128'(t_addr));
                if (t_wr) check("cmp_mem_wdata", mem_wdata, t_data);
            end
            if (icache_resp) check("cmp_irdata", icache_rdata, mem_rdata);
            if (dcache_resp) check("cmp_drdata", dcache_rdata, mem_rdata);
        end
    end

    bit i_seen = 1'b0;
    bit d_seen = 1'b0;
    always @(negedge clk) begin
        i_seen <= icache_resp;
        d_seen <= dcache_resp;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_WD = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        int delay;
        // Reset state
        tick();
        tick();
        #1;
        check("rst_mem_read", 128'(mem_read), 128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_mem_address", 128'(mem_address), 128'd0);
        check("rst_mem_wdata", mem_wdata, 128'd0);
        check("rst_iresp", 128'(icache_resp), 128'd0);
        check("rst_dresp", 128'(dcache_resp), 128'd0);
        tick();
        reset = 1'b1;

        // Lone I-cache read
        tick();
        icache_read = 1'b1;
        icache_address = 16'h1230;
        tick();
        #1;
        check("i_mem_read", 128'(mem_read), 128'd1);
        check("i_mem_write", 128'(mem_write), 128'd0);
        check("i_mem_address", 128'(mem_address), 128'h1230);
        mem_resp = 1'b1;
        mem_rdata = PAT_A5;
        #1;
        check("i_resp", 128'(icache_resp), 128'd1);
        check("i_rdata", icache_rdata, PAT_A5);
        check("i_dresp_quiet", 128'(dcache_resp), 128'd0);
        tick();
        mem_resp = 1'b0;
        icache_read = 1'b0;

        // Lone D-cache writeback, address changes while being served
        tick();
        dcache_write = 1'b1;
        dcache_address = 16'h4440;
        dcache_wdata = PAT_WD;
        tick();
        #1;
        check("d_mem_write", 128'(mem_write), 128'd1);
        check("d_mem_read", 128'(mem_read), 128'd0);
        check("d_mem_wdata", mem_wdata, PAT_WD);
        dcache_address = 16'h9990;
        dcache_wdata = '0;
        tick();
        tick();
        #1;
        check("d_addr_held", 128'(mem_address), 128'h4440);
        check("d_wdata_held", mem_wdata, PAT_WD);
        mem_resp = 1'b1;
        #1;
        check("d_resp", 128'(dcache_resp), 128'd1);
        check("d_iresp_quiet", 128'(icache_resp), 128'd0);
        tick();
        mem_resp = 1'b0;
        dcache_write = 1'b0;

        // Contention right after a fresh reset: D, then I, then D
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        icache_read = 1'b1;
        icache_address = 16'h1000;
        dcache_read = 1'b1;
        dcache_address = 16'h2000;
        tick();
        #1;
        check("c1_winner_d", 128'(mem_address), 128'h2000);
        mem_resp = 1'b1;
        #1;
        check("c1_dresp", 128'(dcache_resp), 128'd1);
        tick();
        mem_resp = 1'b0;
        #1;
        check("c_idle_gap", 128'(mem_read), 128'd0);
        tick();
        #1;
        check("c2_winner_i", 128'(mem_address), 128'h1000);
        check("c2_mem_read", 128'(mem_read), 128'd1);
        mem_resp = 1'b1;
        #1;
        check("c2_iresp", 128'(icache_resp), 128'd1);
        tick();
        mem_resp = 1'b0;
        tick();
        #1;
        check("c3_winner_d", 128'(mem_address), 128'h2000);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        dcache_read = 1'b0;
        tick();
        #1;
        check("c4_i_alone", 128'(mem_address), 128'h1000);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        icache_read = 1'b0;

        // Reset during an I-cache transaction
        tick();
        icache_read = 1'b1;
        icache_address = 16'h5550;
        tick();
        #1;
        check("r_mem_read_before", 128'(mem_read), 128'd1);
        reset = 1'b0;
        mem_resp = 1'b1;
        #1;
        check("r_mem_read_drop", 128'(mem_read), 128'd0);
        check("r_no_iresp", 128'(icache_resp), 128'd0);
        tick();
        reset = 1'b1;
        mem_resp = 1'b0;
        #1;
        check("r_idle", 128'(mem_read), 128'd0);
        tick();
        #1;
        check("r_regrant", 128'(mem_read), 128'd1);
        check("r_regrant_addr", 128'(mem_address), 128'h5550);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        icache_read = 1'b0;

        // Stray memory response while idle
        tick();
        mem_resp = 1'b1;
        #1;
        check("s_no_iresp", 128'(icache_resp), 128'd0);
        check("s_no_dresp", 128'(dcache_resp), 128'd0);
        tick();
        mem_resp = 1'b0;
        #1;
        check("s_still_idle", 128'(mem_read | mem_write), 128'd0);

        // Randomized traffic
        delay = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (mem_resp) begin
                mem_resp = 1'b0;
            end else if (mem_read || mem_write) begin
                if (delay == 0) begin
                    mem_resp = 1'b1;
                    mem_rdata = rnd128();
                    delay = $urandom_range(0, 3);
                end else begin
                    delay--;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                mem_resp = 1'b1;
                mem_rdata = rnd128();
            end

            if (icache_read) begin
                if (i_seen || $urandom_range(0, 39) == 0)
                    icache_read = 1'b0;
                else if ($urandom_range(0, 7) == 0)
                    icache_address = 16'($urandom);
            end else if ($urandom_range(0, 2) == 0) begin
                icache_read = 1'b1;
                icache_address = 16'($urandom);
            end

            if (dcache_read || dcache_write) begin
                if (d_seen || $urandom_range(0, 39) == 0) begin
                    dcache_read = 1'b0;
                    dcache_write = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    dcache_address = 16'($urandom);
                    dcache_wdata = rnd128();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dcache_write = 1'($urandom_range(0, 1));
                dcache_read = !dcache_write;
                dcache_address = 16'($urandom);
                dcache_wdata = rnd128();
            end
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
